// File: rtl/alu_program_sequencer.sv
// alu_program_sequencer
//   Initiator side of the accumulator-ALU opcode/operand interface. Holds a
//   small program of {opcode, operand} words and issues them to the ALU one at
//   a time. After each word, once the ALU latency has elapsed, it captures the
//   ALU result and carry.
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   prog_we/addr/wdata       program memory write port (IDLE only)
//   start, abort             run control
//   alu_opcode, alu_operand  word presented to the ALU (zero outside ISSUE)
//   alu_result, alu_carry    ALU accumulator and carry flag
//   busy, done, pc           run status
//   last_result, last_carry  most recently captured ALU outputs
//
// State table
//   state | meaning
//   IDLE  | not running; program memory writable
//   ISSUE | present mem[pc] to the ALU for one cycle (HALT presents NOP)
//   WAIT  | count down ALU latency, capture result on the final cycle
//   DONE  | one-cycle completion pulse

module alu_program_sequencer #(
  parameter int DEPTH   = 8,
  parameter int OP_W    = 3,
  parameter int DATA_W  = 7,
  parameter int ALU_LAT = 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   prog_we,
  input  logic [ADDR_W-1:0]      prog_addr,
  input  logic [OP_W+DATA_W-1:0] prog_wdata,
  input  logic                   start,
  input  logic                   abort,
  output logic [OP_W-1:0]        alu_opcode,
  output logic [DATA_W-1:0]      alu_operand,
  input  logic [DATA_W-1:0]      alu_result,
  input  logic                   alu_carry,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      pc,
  output logic [DATA_W-1:0]      last_result,
  output logic                   last_carry
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  localparam logic [OP_W-1:0]   OP_HALT = '1;
  localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(DEPTH - 1);

  logic [1:0]               state;
  logic [CNT_W-1:0]         wait_cnt;
  logic [OP_W+DATA_W-1:0]   mem [DEPTH];
  logic [OP_W-1:0]          cur_op;
  logic [DATA_W-1:0]        cur_operand;
  logic                     cur_halt;

  assign {cur_op, cur_operand} = mem[pc];
  assign cur_halt = (cur_op == OP_HALT);

  // Program memory: writes are only accepted while idle so a running program
  // can never be modified under the sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == S_IDLE && prog_we) begin
      mem[prog_addr] <= prog_wdata;
    end
  end

  // Sequencer FSM. Abort takes priority in every state, including IDLE where
  // it suppresses a simultaneous start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      wait_cnt    <= '0;
      last_result <= '0;
      last_carry  <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= '0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cur_halt) begin
            state <= S_DONE;
          end else begin
            wait_cnt <= CNT_W'(ALU_LAT);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == CNT_W'(1)) begin
            last_result <= alu_result;
            last_carry  <= alu_carry;
            // pc saturates at the last word: a program without HALT ends there.
            if (pc == PC_LAST) begin
              state <= S_DONE;
            end else begin
              pc    <= pc + ADDR_W'(1);
              state <= S_ISSUE;
            end
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ALU drive is decoded from registered state so it returns to NOP the
  // moment reset asserts, without waiting for a clock edge.
  always_comb begin
    alu_opcode  = '0;
    alu_operand = '0;
    if (state == S_ISSUE && !cur_halt) begin
      alu_opcode  = cur_op;
      alu_operand = cur_operand;
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_alu_program_sequencer.sv
module tb_alu_program_sequencer;
  localparam int DEPTH  = 8;
  localparam int OP_W   = 3;
  localparam int DATA_W = 7;
  localparam int ADDR_W = 3;
  localparam int W      = OP_W + DATA_W;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              prog_we = 1'b0;
  logic [ADDR_W-1:0] prog_addr = '0;
  logic [W-1:0]      prog_wdata = '0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [OP_W-1:0]   alu_opcode;
  logic [DATA_W-1:0] alu_operand;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              busy, done;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] last_result;
  logic              last_carry;

  alu_program_sequencer #(.DEPTH(DEPTH), .OP_W(OP_W), .DATA_W(DATA_W), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .start(start), .abort(abort),
    .alu_opcode(alu_opcode), .alu_operand(alu_operand),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .busy(busy), .done(done), .pc(pc),
    .last_result(last_result), .last_carry(last_carry)
  );

  always #5 clk = ~clk;

  // Accumulator ALU model, latency 1: executes on the issue edge.
  logic [DATA_W:0] sum;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result <= '0;
      alu_carry  <= 1'b0;
    end else begin
      case (alu_opcode)
        OP_LOAD: begin alu_result <= alu_operand; alu_carry <= 1'b0; end
        OP_ADD:  {alu_carry, alu_result} <= {1'b0, alu_result} + {1'b0, alu_operand};
        OP_SUB:  {alu_carry, alu_result} <= {1'b0, alu_result} - {1'b0, alu_operand};
        default: ;
      endcase
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called and returns at a negedge.
  task automatic write_word(input int addr, input logic [2:0] op, input logic [6:0] d);
    prog_we    = 1'b1;
    prog_addr  = ADDR_W'(addr);
    prog_wdata = {op, d};
    @(negedge clk);
    prog_we    = 1'b0;
  endtask

  // Raises start now (caller sits at a negedge); cycle k is observed at the
  // k-th negedge after the start edge. poke_k>0 writes addr0 during the run.
  task automatic run(input int poke_k, output int done_cyc, output int issues,
                     output int dones, output int busy_after);
    done_cyc = 0; issues = 0; dones = 0; busy_after = -1;
    start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 1'b0; prog_we = 1'b0; end
      if (poke_k > 0 && k == poke_k) begin
        prog_we = 1'b1; prog_addr = '0; prog_wdata = {OP_LOAD, 7'd50};
      end
      if (poke_k > 0 && k == poke_k + 1) prog_we = 1'b0;
      if (alu_opcode != 3'b000) issues++;
      if (done) begin
        dones++;
        if (done_cyc == 0) done_cyc = k;
      end
      if (done_cyc != 0 && k == done_cyc + 1) begin
        busy_after = int'(busy);
        break;
      end
    end
  endtask

  typedef struct {
    logic [2:0] op0; logic [6:0] d0;
    logic [2:0] op1; logic [6:0] d1;
    int res; int cy; int iss;
  } vec_t;

  vec_t tab[6];
  int dc, iss, dn, ba, dn_seen;

  initial begin
    tab[0] = '{OP_LOAD, 7'd5,   OP_ADD, 7'd3,  8,   0, 2};
    tab[1] = '{OP_LOAD, 7'd127, OP_ADD, 7'd1,  0,   1, 2};
    tab[2] = '{OP_LOAD, 7'd10,  OP_SUB, 7'd3,  7,   0, 2};
    tab[3] = '{OP_LOAD, 7'd3,   OP_SUB, 7'd5,  126, 1, 2};
    tab[4] = '{OP_LOAD, 7'd100, OP_NOP, 7'd0,  100, 0, 1};
    tab[5] = '{OP_LOAD, 7'd64,  OP_ADD, 7'd64, 0,   1, 2};

    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pc", pc, 0);
    chk("rst_last_result", last_result, 0);
    chk("rst_last_carry", last_carry, 0);
    chk("rst_opcode", alu_opcode, 0);
    chk("rst_operand", alu_operand, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      write_word(0, tab[i].op0, tab[i].d0);
      write_word(1, tab[i].op1, tab[i].d1);
      write_word(2, OP_HALT, 7'd0);
      run(0, dc, iss, dn, ba);
      chk($sformatf("v%0d_result", i), last_result, tab[i].res);
      chk($sformatf("v%0d_carry", i), last_carry, tab[i].cy);
      chk($sformatf("v%0d_done_cycle", i), dc, 6);
      chk($sformatf("v%0d_issues", i), iss, tab[i].iss);
      chk($sformatf("v%0d_busy_after", i), ba, 0);
    end

    // Eight LOADs, no HALT: runs to the last word.
    for (int i = 0; i < DEPTH; i++) write_word(i, OP_LOAD, 7'(i));
    run(0, dc, iss, dn, ba);
    chk("nohalt_done_cycle", dc, 17);
    chk("nohalt_done_count", dn, 1);
    chk("nohalt_busy_after", ba, 0);
    chk("nohalt_pc", pc, 7);
    chk("nohalt_result", last_result, 7);
    chk("nohalt_issues", iss, 8);

    // Abort during WAIT of word 1 (cycle 4).
    write_word(0, OP_LOAD, 7'd5);
    write_word(1, OP_ADD, 7'd3);
    write_word(2, OP_HALT, 7'd0);
    dn_seen = 0;
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) dn_seen++;
      if (k == 4) begin
        chk("abort_pre_busy", busy, 1);
        abort = 1'b1;
      end
      if (k == 5) begin
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_opcode", alu_opcode, 0);
        chk("abort_last_result", last_result, 5);
      end
    end
    chk("abort_no_done", dn_seen, 0);

    // Abort and start together in IDLE: abort wins.
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_start_busy", busy, 0);
    @(negedge clk);
    chk("abort_start_busy2", busy, 0);

    // prog_we during a run is ignored; rerun gives the same result.
    run(2, dc, iss, dn, ba);
    chk("busywe_result", last_result, 8);
    write_word(1, OP_ADD, 7'd3);
    run(0, dc, iss, dn, ba);
    chk("busywe_rerun_result", last_result, 8);
    chk("busywe_rerun_done_cycle", dc, 6);

    // prog_we with start on the same edge.
    write_word(1, OP_HALT, 7'd0);
    prog_we = 1'b1; prog_addr = '0; prog_wdata = {OP_LOAD, 7'd9};
    run(0, dc, iss, dn, ba);
    chk("we_start_result", last_result, 9);
    chk("we_start_done_cycle", dc, 4);

    // Reset mid-WAIT of word 1.
    write_word(1, OP_ADD, 7'd3);
    write_word(2, OP_HALT, 7'd0);
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    chk("prerst_pc", pc, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_last_result", last_result, 0);
    chk("midrst_last_carry", last_carry, 0);
    chk("midrst_opcode", alu_opcode, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, dc, iss, dn, ba);
    chk("postrst_issues", iss, 0);
    chk("postrst_done_cycle", dc, 17);
    chk("postrst_pc", pc, 7);
    chk("postrst_result", last_result, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
